// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded operands/control, inserts bubbles on
// stall, flush or an empty ID slot, and keeps saturating bubble/flush event counters.
module id_ex_pipe_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             freeze,
    input  logic             flush,
    input  logic             stall,
    input  logic             cnt_clr,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_rd1,
    input  logic [31:0]      id_rd2,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_ALUSrc,
    input  logic [4:0]       id_ALUOp,
    input  logic [1:0]       id_WDSel,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_rd1,
    output logic [31:0]      ex_rd2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic             ex_RegWrite,
    output logic             ID_EX_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic [4:0]       ex_ALUOp,
    output logic [1:0]       ex_WDSel,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             vld_p1;
    logic [31:0]      pc_p1;
    logic [31:0]      rd1_p1;
    logic [31:0]      rd2_p1;
    logic [31:0]      imm_p1;
    logic [4:0]       rs1_p1;
    logic [4:0]       rs2_p1;
    logic [4:0]       rd_p1;
    logic             reg_write_p1;
    logic             mem_read_p1;
    logic             mem_write_p1;
    logic             alu_src_p1;
    logic [4:0]       alu_op_p1;
    logic [1:0]       wd_sel_p1;
    logic [CNT_W-1:0] bubble_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;
    logic             insert_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // A bubble clears indices and MemRead too, so it never looks like a hazard or forward source.
    assign insert_bubble = flush | stall | ~id_valid;

    // ID -> EX stage boundary
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            rd1_p1       <= '0;
            rd2_p1       <= '0;
            imm_p1       <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            alu_src_p1   <= 1'b0;
            alu_op_p1    <= '0;
            wd_sel_p1    <= '0;
        end else if (!freeze) begin
            if (insert_bubble) begin
                vld_p1       <= 1'b0;
                pc_p1        <= '0;
                rd1_p1       <= '0;
                rd2_p1       <= '0;
                imm_p1       <= '0;
                rs1_p1       <= '0;
                rs2_p1       <= '0;
                rd_p1        <= '0;
                reg_write_p1 <= 1'b0;
                mem_read_p1  <= 1'b0;
                mem_write_p1 <= 1'b0;
                alu_src_p1   <= 1'b0;
                alu_op_p1    <= '0;
                wd_sel_p1    <= '0;
            end else begin
                vld_p1       <= 1'b1;
                pc_p1        <= id_pc;
                rd1_p1       <= id_rd1;
                rd2_p1       <= id_rd2;
                imm_p1       <= id_imm;
                rs1_p1       <= id_rs1;
                rs2_p1       <= id_rs2;
                rd_p1        <= id_rd;
                reg_write_p1 <= id_RegWrite;
                mem_read_p1  <= id_MemRead;
                mem_write_p1 <= id_MemWrite;
                alu_src_p1   <= id_ALUSrc;
                alu_op_p1    <= id_ALUOp;
                wd_sel_p1    <= id_WDSel;
            end
        end
    end

    // A simultaneous flush and stall is accounted as a flush only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt_p1 <= '0;
            flush_cnt_p1  <= '0;
        end else if (!freeze) begin
            if (cnt_clr) begin
                bubble_cnt_p1 <= '0;
                flush_cnt_p1  <= '0;
            end else if (flush) begin
                flush_cnt_p1  <= sat_inc(flush_cnt_p1);
            end else if (stall) begin
                bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
            end
        end
    end

    assign ex_valid      = vld_p1;
    assign ex_pc         = pc_p1;
    assign ex_rd1        = rd1_p1;
    assign ex_rd2        = rd2_p1;
    assign ex_imm        = imm_p1;
    assign ID_EX_rs1     = rs1_p1;
    assign ID_EX_rs2     = rs2_p1;
    assign ID_EX_rd      = rd_p1;
    assign ex_RegWrite   = reg_write_p1;
    assign ID_EX_MemRead = mem_read_p1;
    assign ex_MemWrite   = mem_write_p1;
    assign ex_ALUSrc     = alu_src_p1;
    assign ex_ALUOp      = alu_op_p1;
    assign ex_WDSel      = wd_sel_p1;
    assign bubble_cnt    = bubble_cnt_p1;
    assign flush_cnt     = flush_cnt_p1;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        alusrc;
        logic [4:0]  op;
        logic [1:0]  wd;
        logic [15:0] bc;
        logic [15:0] fc;
        logic [3:0]  bc4;
        logic [3:0]  fc4;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic freeze = 1'b0, flush = 1'b0, stall = 1'b0, cnt_clr = 1'b0;
    exp_t idv = '0;

    logic        ex_valid, ex_RegWrite, ID_EX_MemRead, ex_MemWrite, ex_ALUSrc;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ex_ALUOp;
    logic [1:0]  ex_WDSel;
    logic [15:0] bubble_cnt, flush_cnt;

    logic        d4_valid, d4_rw, d4_mr, d4_mw, d4_as;
    logic [31:0] d4_pc, d4_rd1, d4_rd2, d4_imm;
    logic [4:0]  d4_rs1, d4_rs2, d4_rd, d4_op;
    logic [1:0]  d4_wd;
    logic [3:0]  d4_bc, d4_fc;

    exp_t m = '0;
    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.CNT_W(16)) u_dut (
        .clk(clk), .rstn(rstn), .freeze(freeze), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
        .id_valid(idv.valid), .id_pc(idv.pc), .id_rd1(idv.rd1), .id_rd2(idv.rd2), .id_imm(idv.imm),
        .id_rs1(idv.rs1), .id_rs2(idv.rs2), .id_rd(idv.rd), .id_RegWrite(idv.rw),
        .id_MemRead(idv.mr), .id_MemWrite(idv.mw), .id_ALUSrc(idv.alusrc), .id_ALUOp(idv.op),
        .id_WDSel(idv.wd), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_imm(ex_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ex_RegWrite(ex_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_WDSel(ex_WDSel),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .freeze(freeze), .flush(flush), .stall(stall), .cnt_clr(cnt_clr),
        .id_valid(idv.valid), .id_pc(idv.pc), .id_rd1(idv.rd1), .id_rd2(idv.rd2), .id_imm(idv.imm),
        .id_rs1(idv.rs1), .id_rs2(idv.rs2), .id_rd(idv.rd), .id_RegWrite(idv.rw),
        .id_MemRead(idv.mr), .id_MemWrite(idv.mw), .id_ALUSrc(idv.alusrc), .id_ALUOp(idv.op),
        .id_WDSel(idv.wd), .ex_valid(d4_valid), .ex_pc(d4_pc), .ex_rd1(d4_rd1), .ex_rd2(d4_rd2),
        .ex_imm(d4_imm), .ID_EX_rs1(d4_rs1), .ID_EX_rs2(d4_rs2), .ID_EX_rd(d4_rd),
        .ex_RegWrite(d4_rw), .ID_EX_MemRead(d4_mr), .ex_MemWrite(d4_mw),
        .ex_ALUSrc(d4_as), .ex_ALUOp(d4_op), .ex_WDSel(d4_wd),
        .bubble_cnt(d4_bc), .flush_cnt(d4_fc)
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] pack_data(input exp_t e);
        return {5'b0, e.valid, e.pc, e.rd1, e.rd2, e.imm, e.rs1, e.rs2, e.rd,
                e.rw, e.mr, e.mw, e.alusrc, e.op, e.wd};
    endfunction

    task automatic compare(input exp_t e);
        chk("ex_valid", 160'(ex_valid), 160'(e.valid));
        chk("ex_pc", 160'(ex_pc), 160'(e.pc));
        chk("ex_rd1", 160'(ex_rd1), 160'(e.rd1));
        chk("ex_rd2", 160'(ex_rd2), 160'(e.rd2));
        chk("ex_imm", 160'(ex_imm), 160'(e.imm));
        chk("ID_EX_rs1", 160'(ID_EX_rs1), 160'(e.rs1));
        chk("ID_EX_rs2", 160'(ID_EX_rs2), 160'(e.rs2));
        chk("ID_EX_rd", 160'(ID_EX_rd), 160'(e.rd));
        chk("ex_RegWrite", 160'(ex_RegWrite), 160'(e.rw));
        chk("ID_EX_MemRead", 160'(ID_EX_MemRead), 160'(e.mr));
        chk("ex_MemWrite", 160'(ex_MemWrite), 160'(e.mw));
        chk("ex_ALUSrc", 160'(ex_ALUSrc), 160'(e.alusrc));
        chk("ex_ALUOp", 160'(ex_ALUOp), 160'(e.op));
        chk("ex_WDSel", 160'(ex_WDSel), 160'(e.wd));
        chk("bubble_cnt", 160'(bubble_cnt), 160'(e.bc));
        chk("flush_cnt", 160'(flush_cnt), 160'(e.fc));
        chk("cnt4 {bubble,flush}", 160'({d4_bc, d4_fc}), 160'({e.bc4, e.fc4}));
        chk("dut4 data", {5'b0, d4_valid, d4_pc, d4_rd1, d4_rd2, d4_imm, d4_rs1, d4_rs2, d4_rd,
                          d4_rw, d4_mr, d4_mw, d4_as, d4_op, d4_wd}, pack_data(e));
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) compare(q.pop_front());
    end

    always @(negedge rstn) begin
        #1;
        if (q.size() > 0) compare(q.pop_front());
    end

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] ctl,
                          input logic [4:0] op, input logic [1:0] wd);
        idv = '0;
        idv.valid = v; idv.pc = pc; idv.rd1 = rd1; idv.rd2 = rd2; idv.imm = imm;
        idv.rs1 = rs1; idv.rs2 = rs2; idv.rd = rd;
        {idv.rw, idv.mr, idv.mw, idv.alusrc} = ctl;
        idv.op = op; idv.wd = wd;
    endtask

    // Drive one cycle of controls, queue the expected EX contents after the edge.
    task automatic step(input logic fr, input logic fl, input logic st, input logic clr);
        exp_t n;
        freeze = fr; flush = fl; stall = st; cnt_clr = clr;
        n = m;
        if (!fr) begin
            n = '0;
            n.bc = m.bc; n.fc = m.fc; n.bc4 = m.bc4; n.fc4 = m.fc4;
            if (!fl && !st && idv.valid) begin
                n.valid = 1'b1; n.pc = idv.pc; n.rd1 = idv.rd1; n.rd2 = idv.rd2;
                n.imm = idv.imm; n.rs1 = idv.rs1; n.rs2 = idv.rs2; n.rd = idv.rd;
                n.rw = idv.rw; n.mr = idv.mr; n.mw = idv.mw; n.alusrc = idv.alusrc;
                n.op = idv.op; n.wd = idv.wd;
            end
            if (clr) begin
                n.bc = 0; n.fc = 0; n.bc4 = 0; n.fc4 = 0;
            end else if (fl) begin
                if (n.fc != 16'hFFFF) n.fc = n.fc + 1;
                if (n.fc4 != 4'hF) n.fc4 = n.fc4 + 1;
            end else if (st) begin
                if (n.bc != 16'hFFFF) n.bc = n.bc + 1;
                if (n.bc4 != 4'hF) n.bc4 = n.bc4 + 1;
            end
        end
        m = n;
        q.push_back(m);
        @(negedge clk);
    endtask

    initial begin
        exp_t snap;
        #1;
        // Reset held across two edges with a busy ID stage.
        set_id(1, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'hF, 5'd7, 2'd3);
        flush = 1'b1; stall = 1'b1;
        q.push_back('0);
        @(negedge clk);
        q.push_back('0);
        @(negedge clk);
        m = '0;
        rstn = 1'b1;

        set_id(1, 32'h10, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5, 4'b0100, 5'd0, 2'd0);
        step(0, 0, 0, 0);
        chk("first load ex_valid", 160'(ex_valid), 160'(1));
        chk("first load ex_pc", 160'(ex_pc), 160'(32'h10));
        chk("first load rd", 160'(ID_EX_rd), 160'(5));
        chk("first load MemRead", 160'(ID_EX_MemRead), 160'(1));
        chk("first load counters", 160'({bubble_cnt, flush_cnt}), 160'(0));

        set_id(1, 32'h14, 32'hAAAA_0001, 32'h5555_0002, 32'hFFFF_FFFC, 5'd5, 5'd7, 5'd6,
               4'b1001, 5'd3, 2'd1);
        step(0, 0, 1, 0);
        chk("stall bubble valid", 160'(ex_valid), 160'(0));
        chk("stall bubble rd", 160'(ID_EX_rd), 160'(0));
        chk("stall bubble MemRead", 160'(ID_EX_MemRead), 160'(0));
        chk("stall bubble_cnt", 160'(bubble_cnt), 160'(1));
        step(0, 0, 0, 0);
        chk("after stall rd", 160'(ID_EX_rd), 160'(6));

        set_id(1, 32'h18, 32'h1234_5678, 32'h8765_4321, 32'h0000_0800, 5'd9, 5'd10, 5'd11,
               4'b1111, 5'd12, 2'd2);
        step(0, 1, 1, 0);
        chk("flush+stall flush_cnt", 160'(flush_cnt), 160'(1));
        chk("flush+stall bubble_cnt", 160'(bubble_cnt), 160'(1));
        chk("flush+stall valid", 160'(ex_valid), 160'(0));

        set_id(1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0BAD_F00D, 32'h7FF, 5'd31, 5'd30, 5'd29,
               4'b1010, 5'd31, 2'd3);
        step(0, 0, 0, 0);
        snap = m;
        set_id(1, 32'h0000_0200, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd6, 4'b0101, 5'd1, 2'd0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
        chk("freeze hold pc", 160'(ex_pc), 160'(32'h100));
        chk("freeze hold counters", 160'({bubble_cnt, flush_cnt}), 160'({snap.bc, snap.fc}));

        set_id(0, 32'h0000_0300, 32'h9, 32'h9, 32'h9, 5'd1, 5'd1, 5'd1, 4'hF, 5'd1, 2'd1);
        step(0, 0, 0, 0);
        chk("invalid id bubble", 160'(ex_valid), 160'(0));

        for (int i = 0; i < 4; i++) begin
            set_id(1, 32'h400 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), ~(32'h1 << i),
                   32'h8000_0000 >> i, 5'(i + 1), 5'(i + 16), 5'(31 - i), 4'(i * 5),
                   5'(i * 7), 2'(i));
            step(0, 0, 0, 0);
        end

        set_id(1, 32'h500, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'b0100, 5'd4, 2'd1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        chk("sat bubble_cnt4", 160'(d4_bc), 160'(15));
        chk("bubble_cnt after 20", 160'(bubble_cnt), 160'(21));
        step(0, 0, 1, 1);
        chk("clr bubble_cnt4", 160'(d4_bc), 160'(0));
        chk("clr bubble_cnt", 160'(bubble_cnt), 160'(0));
        for (int i = 0; i < 18; i++) step(0, 1, 0, 0);
        chk("sat flush_cnt4", 160'(d4_fc), 160'(15));
        chk("flush_cnt after 18", 160'(flush_cnt), 160'(18));

        set_id(1, 32'h600, 32'h6, 32'h7, 32'h8, 5'd2, 5'd3, 5'd4, 4'b1100, 5'd5, 2'd2);
        step(0, 0, 0, 0);
        #2;
        m = '0;
        q.push_back('0);
        rstn = 1'b0;
        #1;
        chk("async reset valid", 160'(ex_valid), 160'(0));
        chk("async reset flush_cnt", 160'(flush_cnt), 160'(0));
        #1;
        rstn = 1'b1;
        step(0, 0, 0, 0);
        chk("reload after reset", 160'(ex_pc), 160'(32'h600));

        repeat (2) @(negedge clk);
        chk("scoreboard drained", 160'(q.size()), 160'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RISC-V pipeline, directly downstream of the decode stage.
- Captures decoded operands and control each cycle.
- Inserts a bubble on a load-use stall (stall from the hazard detector) or on a branch/jal flush.
- Holds its contents when the pipeline is frozen.
- Feeds ID_EX_rd, ID_EX_MemRead, ID_EX_rs1 and ID_EX_rs2 back to the hazard detector and forwarding unit.
- Keeps saturating bubble and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the bubble and flush event counters.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- freeze  in  1  global hold (memory not ready); all state holds.
- flush  in  1  branch/jal taken in EX; squash the instruction entering EX.
- stall  in  1  load-use stall from the hazard detector.
- cnt_clr  in  1  synchronous clear of both counters.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_rd1, id_rd2  in  32  register-file read data.
- id_imm  in  32  immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc  in  1  control.
- id_ALUOp  in  5  ALU operation.
- id_WDSel  in  2  writeback select.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  32  registered copies.
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5  registered indices.
- ex_RegWrite, ID_EX_MemRead, ex_MemWrite, ex_ALUSrc  out  1  registered control.
- ex_ALUOp  out  5  registered ALU operation.
- ex_WDSel  out  2  registered writeback select.
- bubble_cnt  out  CNT_W  count of stall-induced bubbles.
- flush_cnt  out  CNT_W  count of flush events.

Behaviour:
- Reset (rstn=0, asynchronous): every output is 0. EX therefore holds a bubble.
- Per rising edge, the first matching case applies (priority order):
  1. freeze=1: all registers hold, including counters. cnt_clr is ignored while frozen.
  2. flush=1: load a bubble.
  3. stall=1: load a bubble.
  4. id_valid=0: load a bubble.
  5. Otherwise: load all id_* fields into the ex_* outputs and set ex_valid=1. Latency is 1 cycle.
- Bubble definition: ex_valid=0, and all data, index and control outputs are 0. In particular, ID_EX_rd=0, ID_EX_rs1=0, ID_EX_rs2=0 and ID_EX_MemRead=0, so a bubble never triggers a hazard or a forward.
- flush and stall together: the cycle counts as a flush, not as a bubble.
- Counters:
  - When not frozen, cnt_clr=1 zeroes both counters that edge; the clear takes priority over increment.
  - Otherwise flush_cnt increments on flush=1.
  - bubble_cnt increments on stall=1 && flush=0.
  - Both saturate at 2^CNT_W-1 (no wrap).
- This block does not gate stall. The upstream IF/ID and PC hold on stall is the responsibility of the IF/ID register and PC logic.
- Reset asserted mid-operation clears everything immediately. The first edge after deassertion behaves per the priority list.

Test Plan:
- Reset, then id_valid=1, id_pc=0x00000010, id_rd=5, id_MemRead=1, no controls asserted -> after 1 edge: ex_valid=1, ex_pc=0x10, ID_EX_rd=5, ID_EX_MemRead=1, both counters 0.
- Load in EX, then stall=1 for one cycle with an ID instruction having rd=6 -> next edge: ex_valid=0, ID_EX_rd=0, ID_EX_MemRead=0, bubble_cnt=1. Following edge with stall=0 loads rd=6.
- flush=1 and stall=1 in the same cycle -> bubble loaded, flush_cnt=1, bubble_cnt unchanged.
- freeze=1 for 3 cycles with flush=1, stall=1 and cnt_clr=1 all asserted -> all outputs and counters identical to their pre-freeze values.
- CNT_W=4, stall held 20 cycles -> bubble_cnt=15 and holds. Then cnt_clr=1 with stall=1 -> bubble_cnt=0.
- rstn pulsed low between clock edges while ex_valid=1 -> all outputs 0 immediately, without a clock edge.
